// File: rtl/key_hit_detector.sv
// Counts finger-coloured pixels inside a piano-key region each camera frame and
// debounces the per-frame count into a pressed state. Optional: KEY_HIT_DEBOUNCE_EN.
module key_hit_detector #(
    parameter int unsigned WIDTH            = 64,
    parameter int unsigned HEIGHT           = 64,
    parameter int unsigned BLACK_KEY_WIDTH  = 15,
    parameter int unsigned BLACK_KEY_HEIGHT = 64,
    parameter logic [7:0]  RED_MIN          = 8'hA0,
    parameter logic [7:0]  GREEN_MAX        = 8'h60,
    parameter logic [7:0]  BLUE_MAX         = 8'h60,
    parameter int unsigned PRESS_THRESH     = 200,
    parameter int unsigned RELEASE_THRESH   = 100,
    parameter int unsigned DEBOUNCE_FRAMES  = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [10:0] x,
    input  logic [9:0]  y,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic [23:0] pixel,
    input  logic        pixel_valid,
    input  logic        frame_start,
    output logic        pressed,
    output logic        press_pulse,
    output logic        release_pulse,
    output logic [15:0] hit_count,
    output logic        count_valid
);

    localparam int unsigned CW = 12;
    localparam int unsigned AW = 16;

    if (RELEASE_THRESH > PRESS_THRESH) begin : g_bad_thresh
        $error("key_hit_detector: RELEASE_THRESH must not exceed PRESS_THRESH");
    end
    if (DEBOUNCE_FRAMES == 0 || DEBOUNCE_FRAMES > 7) begin : g_bad_debounce
        $error("key_hit_detector: DEBOUNCE_FRAMES must be in 1..7");
    end

    // Region test in 12 bits so the right/bottom edges never wrap
    logic [CW-1:0] hc_w, vc_w, x_lo, x_hi, x_notch, y_lo, y_hi, y_notch;
    logic          in_key_c;
    logic          colour_c;
    logic          hit_c;

    assign hc_w    = {1'b0, hcount};
    assign vc_w    = {2'b00, vcount};
    assign x_lo    = {1'b0, x};
    assign y_lo    = {2'b00, y};
    assign x_hi    = x_lo + CW'(WIDTH);
    assign y_hi    = y_lo + CW'(HEIGHT);
    assign x_notch = x_lo + CW'(BLACK_KEY_WIDTH);
    assign y_notch = y_lo + CW'(BLACK_KEY_HEIGHT);

    assign in_key_c = (hc_w >= x_lo) && (hc_w < x_hi) &&
                      (vc_w >= y_lo) && (vc_w < y_hi) &&
                      !((hc_w < x_notch) && (vc_w < y_notch));
    assign colour_c = (pixel[23:16] >= RED_MIN) && (pixel[15:8] <= GREEN_MAX) &&
                      (pixel[7:0] <= BLUE_MAX);
    assign hit_c    = pixel_valid && in_key_c && colour_c;

    logic [AW-1:0] acc_q, acc_d;
    logic [AW-1:0] hit_count_q;
    logic          count_valid_q;

    // A hit on the frame_start cycle belongs to the new frame
    always_comb begin
        acc_d = acc_q;
        if (frame_start) begin
            acc_d = {{(AW-1){1'b0}}, hit_c};
        end else if (hit_c && (acc_q != {AW{1'b1}})) begin
            acc_d = acc_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_q         <= '0;
            hit_count_q   <= '0;
            count_valid_q <= 1'b0;
        end else begin
            acc_q         <= acc_d;
            count_valid_q <= frame_start;
            if (frame_start) begin
                hit_count_q <= acc_q;
            end
        end
    end

    logic press_qual_c;
    logic release_qual_c;
    logic pressed_q, press_pulse_q, release_pulse_q;

    assign press_qual_c   = acc_q >= AW'(PRESS_THRESH);
    assign release_qual_c = acc_q <  AW'(RELEASE_THRESH);

`ifdef KEY_HIT_DEBOUNCE_EN
    typedef enum logic [1:0] {RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND} state_t;

    localparam logic [2:0] DB_N = 3'(DEBOUNCE_FRAMES);

    state_t     state_q;
    logic [2:0] fcnt_q;

    // Needs DB_N consecutive qualifying frames; any other frame aborts a PEND state
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q         <= RELEASED;
            fcnt_q          <= 3'd0;
            pressed_q       <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
        end else begin
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            if (frame_start) begin
                case (state_q)
                    RELEASED: begin
                        if (press_qual_c) begin
                            if (DB_N == 3'd1) begin
                                state_q       <= PRESSED;
                                pressed_q     <= 1'b1;
                                press_pulse_q <= 1'b1;
                                fcnt_q        <= 3'd0;
                            end else begin
                                state_q <= PRESS_PEND;
                                fcnt_q  <= 3'd1;
                            end
                        end
                    end
                    PRESS_PEND: begin
                        if (press_qual_c) begin
                            if (fcnt_q + 3'd1 == DB_N) begin
                                state_q       <= PRESSED;
                                pressed_q     <= 1'b1;
                                press_pulse_q <= 1'b1;
                                fcnt_q        <= 3'd0;
                            end else begin
                                fcnt_q <= fcnt_q + 3'd1;
                            end
                        end else begin
                            state_q <= RELEASED;
                            fcnt_q  <= 3'd0;
                        end
                    end
                    PRESSED: begin
                        if (release_qual_c) begin
                            if (DB_N == 3'd1) begin
                                state_q         <= RELEASED;
                                pressed_q       <= 1'b0;
                                release_pulse_q <= 1'b1;
                                fcnt_q          <= 3'd0;
                            end else begin
                                state_q <= RELEASE_PEND;
                                fcnt_q  <= 3'd1;
                            end
                        end
                    end
                    RELEASE_PEND: begin
                        if (release_qual_c) begin
                            if (fcnt_q + 3'd1 == DB_N) begin
                                state_q         <= RELEASED;
                                pressed_q       <= 1'b0;
                                release_pulse_q <= 1'b1;
                                fcnt_q          <= 3'd0;
                            end else begin
                                fcnt_q <= fcnt_q + 3'd1;
                            end
                        end else begin
                            state_q <= PRESSED;
                            fcnt_q  <= 3'd0;
                        end
                    end
                    default: begin
                        state_q   <= RELEASED;
                        pressed_q <= 1'b0;
                        fcnt_q    <= 3'd0;
                    end
                endcase
            end
        end
    end
`else
    typedef enum logic {RELEASED, PRESSED} state_t;

    state_t state_q;

    // Single-frame decision with the same press/release hysteresis band
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q         <= RELEASED;
            pressed_q       <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
        end else begin
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            if (frame_start) begin
                if (state_q == RELEASED) begin
                    if (press_qual_c) begin
                        state_q       <= PRESSED;
                        pressed_q     <= 1'b1;
                        press_pulse_q <= 1'b1;
                    end
                end else if (release_qual_c) begin
                    state_q         <= RELEASED;
                    pressed_q       <= 1'b0;
                    release_pulse_q <= 1'b1;
                end
            end
        end
    end
`endif

    assign pressed       = pressed_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign hit_count     = hit_count_q;
    assign count_valid   = count_valid_q;

endmodule

// File: doc/key_hit_detector.md
KEY_HIT_DETECTOR -- requirements
Module: key_hit_detector

Interface
REQ-001 SHALL have parameter WIDTH, default 64, meaning key region width in pixels.
REQ-002 SHALL have parameter HEIGHT, default 64, meaning key region height in pixels.
REQ-003 SHALL have parameter BLACK_KEY_WIDTH, default 15, meaning width of excluded top-left notch.
REQ-004 SHALL have parameter BLACK_KEY_HEIGHT, default 64, meaning height of excluded top-left notch.
REQ-005 SHALL have parameters RED_MIN, default 8'hA0; GREEN_MAX, default 8'h60; BLUE_MAX, default 8'h60, meaning the finger-colour classification bounds.
REQ-006 SHALL have parameter PRESS_THRESH, default 200, meaning the per-frame hit count that qualifies a press.
REQ-007 SHALL have parameter RELEASE_THRESH, default 100, meaning the per-frame hit count below which a frame qualifies a release; the design SHALL require RELEASE_THRESH <= PRESS_THRESH.
REQ-008 SHALL have parameter DEBOUNCE_FRAMES, default 3, range 1..7, meaning consecutive qualifying frames required.
REQ-009 Ports, in this order:
- clk  in  1  sole clock.
- reset_n  in  1  synchronous, active-low reset.
- x  in  11  key left edge.
- y  in  10  key top edge.
- hcount  in  11  camera pixel column.
- vcount  in  10  camera pixel row.
- pixel  in  24  camera RGB 8:8:8, R in [23:16].
- pixel_valid  in  1  pixel/hcount/vcount are valid this cycle.
- frame_start  in  1  one-cycle pulse marking the first cycle of a new frame.
- pressed  out  1  debounced key state.
- press_pulse  out  1  one-cycle pulse on the released-to-pressed transition.
- release_pulse  out  1  one-cycle pulse on the pressed-to-released transition.
- hit_count  out  16  hit total of the last completed frame.
- count_valid  out  1  one-cycle pulse when hit_count updates.

Function
REQ-010 Region: in_key SHALL be true iff x<=hcount<x+WIDTH and y<=vcount<y+HEIGHT, and NOT (hcount<x+BLACK_KEY_WIDTH and vcount<y+BLACK_KEY_HEIGHT); comparisons SHALL use 12-bit sums so that x+WIDTH never wraps.
REQ-011 Hit: hit SHALL equal pixel_valid & in_key & R>=RED_MIN & G<=GREEN_MAX & B<=BLUE_MAX, evaluated combinationally in the same cycle.
REQ-012 The internal 16-bit accumulator SHALL increment by 1 on each hit cycle and SHALL saturate at 16'hFFFF.
REQ-013 On a frame_start cycle: hit_count SHALL load the accumulator value, excluding the current cycle's hit; the accumulator SHALL load 1 if hit, else 0; count_valid SHALL be 1 in the following cycle only.
REQ-014 The FSM SHALL have states RELEASED, PRESS_PEND, PRESSED and RELEASE_PEND, with a 3-bit frame counter fcnt, and SHALL evaluate only on frame_start cycles using the closing count C.
REQ-015 RELEASED: if C>=PRESS_THRESH, go to PRESS_PEND with fcnt=1; if DEBOUNCE_FRAMES==1, go directly to PRESSED instead.
REQ-016 PRESS_PEND: if C>=PRESS_THRESH, increment fcnt and go to PRESSED when fcnt+1==DEBOUNCE_FRAMES; otherwise return to RELEASED.
REQ-017 PRESSED and RELEASE_PEND SHALL mirror REQ-015 and REQ-016 using C<RELEASE_THRESH. A non-qualifying frame in RELEASE_PEND SHALL return the FSM to PRESSED.
REQ-018 pressed SHALL be 1 in PRESSED and RELEASE_PEND. press_pulse and release_pulse SHALL be registered and high for exactly one cycle after the edge on which the transition is taken.
REQ-019 Counts between RELEASE_THRESH and PRESS_THRESH-1 SHALL hold PRESSED/RELEASED (hysteresis) and SHALL abort either PEND state.
REQ-020 pixel_valid low SHALL never count. frame_start is independent of pixel_valid.
REQ-021 Changes to x or y mid-frame SHALL take effect on the next cycle; no error SHALL be flagged.

Reset
REQ-022 With reset_n low at a clk edge: the FSM SHALL go to RELEASED; fcnt, the accumulator and hit_count SHALL be 0; pressed, press_pulse, release_pulse and count_valid SHALL be 0.
REQ-023 A reset mid-frame SHALL discard the partial count. The first frame_start after reset SHALL report the hits counted since reset.

Configuration
REQ-024 With macro KEY_HIT_DEBOUNCE_EN defined, the FSM SHALL behave per REQ-014..REQ-019.
REQ-025 Without KEY_HIT_DEBOUNCE_EN, the PEND states and fcnt SHALL be absent, and each frame_start SHALL go directly to PRESSED if C>=PRESS_THRESH, or to RELEASED if C<RELEASE_THRESH; pulses and hysteresis SHALL be unchanged.

Verification
REQ-026 Frame with 250 red (FF2020) pixels in the key body, three consecutive frames, defaults -> pressed rises after the third frame_start and press_pulse fires exactly once.
REQ-027 250 red pixels placed only in the notch (hcount<x+15, vcount<y+64) -> hit_count=0 and pressed stays 0.
REQ-028 Frame counts 250, 250, 150, 250, 250, 250 -> PRESS_PEND aborts at 150, and pressed rises only after the sixth frame_start.
REQ-029 Pressed key, then frame counts 150 ×5 -> pressed held (hysteresis); then 50 ×3 -> release_pulse fires once and pressed goes to 0.
REQ-030 70000 hits in one frame -> hit_count=FFFF. A hit coincident with frame_start -> excluded from hit_count, and the next frame starts at 1.
REQ-031 reset_n low mid-PRESS_PEND after 120 hits -> all outputs 0; next frame_start with 0 further hits -> hit_count=0, count_valid pulses.
